// File: rtl/program_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream from the host,
// packs it into instruction words and writes them into instruction RAM while holding the cores halted.
module program_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_data,
  output logic                  mem_wren,
  output logic                  cores_halt,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BYTES = WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR} state_t;

  state_t           state;
  logic [7:0]       len_lo;
  logic [15:0]      n_words;
  logic [IW-1:0]    byte_idx;
  logic [WIDTH-1:0] word_buf;
  logic [WIDTH-1:0] word_nxt;
  logic [16:0]      len_ext;
  logic [16:0]      wl_inc;

  assign in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign len_ext  = {1'b0, in_data, len_lo};
  assign wl_inc   = 17'(words_loaded) + 17'd1;

  // Word with the incoming byte merged in, so the last byte can be written straight out.
  always_comb begin
    word_nxt = word_buf;
    word_nxt[{byte_idx, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_lo       <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      cores_halt   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN0;
            words_loaded <= '0;
            byte_idx     <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cores_halt   <= 1'b1;
          end
        end
        LEN0: begin
          if (in_valid) begin
            len_lo <= in_data;
            state  <= LEN1;
          end
        end
        LEN1: begin
          if (in_valid) begin
            n_words <= {in_data, len_lo};
            // A full-depth load is legal; anything larger would wrap the address.
            if (len_ext == 17'd0 || len_ext > MAX_WORDS) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (in_valid) begin
            word_buf <= word_nxt;
            if (byte_idx == IW'(BYTES - 1)) begin
              byte_idx    <= '0;
              mem_wren    <= 1'b1;
              mem_address <= words_loaded[ADDR_WIDTH-1:0];
              mem_data    <= word_nxt;
              state       <= WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          if (wl_inc < {1'b0, n_words}) begin
            state <= DATA;
          end else begin
            state      <= DONE;
            done       <= 1'b1;
            cores_halt <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
